// File: rtl/ptosda_frame_if.sv
// ptosda_frame_if: producer handshake and two-wire line bundle for ptosda_frame.
interface ptosda_frame_if #(parameter int DATA_W = 8);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              done;
    logic              scl;
    logic              sda;
    modport master (output valid, data, input ready, done, scl, sda);
    modport slave  (input valid, data, output ready, done, scl, sda);
endinterface

// File: rtl/ptosda_frame.sv
// ptosda_frame: parallel-to-serial two-wire frame sender (start, data, optional parity, stop).
// Define PARITY_EN to append an even-parity bit after the data bits.
module ptosda_frame #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1
) (
    input logic           sclk,
    input logic           rst,
    ptosda_frame_if.slave bus
);
`ifdef PARITY_EN
    localparam int NB = DATA_W + 1;
`else
    localparam int NB = DATA_W;
`endif
    localparam int CW = $clog2(NB + 1);
    typedef enum logic [2:0] {IDLE, START, BIT_LO, BIT_HI, STOP_LO, STOP_HI, STOP_REL} state_t;
    state_t        state, state_n;
    logic [NB-1:0] sr, sr_n, load;
    logic [CW-1:0] cnt, cnt_n;
    logic          accept, last, bit_n, scl_n, sda_n, ready_n, done_n;
    assign accept = bus.valid & bus.ready;
    assign last   = cnt == CW'(NB - 1);
`ifdef PARITY_EN
    // Parity sits in the slot that leaves the shifter last.
    assign load = MSB_FIRST ? {bus.data, ^bus.data} : {^bus.data, bus.data};
`else
    assign load = bus.data;
`endif
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            bus.scl   <= 1'b1;
            bus.sda   <= 1'b1;
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            cnt       <= cnt_n;
            bus.scl   <= scl_n;
            bus.sda   <= sda_n;
            bus.ready <= ready_n;
            bus.done  <= done_n;
        end
    end
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:     state_n = accept ? START : IDLE;
            START:    state_n = BIT_LO;
            BIT_LO:   state_n = BIT_HI;
            BIT_HI:   state_n = last ? STOP_LO : BIT_LO;
            STOP_LO:  state_n = STOP_HI;
            STOP_HI:  state_n = STOP_REL;
            STOP_REL: state_n = accept ? START : IDLE;
            default:  state_n = IDLE;
        endcase
        sr_n  = accept ? load : state == BIT_HI ? (MSB_FIRST ? sr << 1 : sr >> 1) : sr;
        cnt_n = state == BIT_HI ? (last ? '0 : cnt + CW'(1)) : cnt;
    end
    // Outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        bit_n   = MSB_FIRST ? sr_n[NB-1] : sr_n[0];
        scl_n   = !(state_n inside {BIT_LO, STOP_LO});
        sda_n   = state_n inside {IDLE, STOP_REL} ? 1'b1 : state_n inside {BIT_LO, BIT_HI} ? bit_n : 1'b0;
        ready_n = state_n inside {IDLE, STOP_REL};
        done_n  = state_n == STOP_REL;
    end
endmodule

// File: doc/ptosda_frame.md
# ptosda_frame

Parametrised parallel-to-serial two-wire transmitter, the next generation of the team's 4-bit `ptosda` sender. It accepts a DATA_W-bit word through a valid/ready handshake and serialises it onto `scl`/`sda` as one frame: start condition, data bits, optional parity bit, stop condition. Bit order is selectable. It sits between a parallel producer and the two-wire line. It derives `scl` from `sclk` internally, and it holds the line idle-high between frames.

## Interface
- DATA_W, 8: payload width in bits, 2..32.
- MSB_FIRST, 1: 1 sends data[DATA_W-1] first; 0 sends data[0] first.

- sclk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- valid  input  1  producer has a word on `data`.
- data  input  DATA_W  word to send; sampled only on the accept edge.
- ready  output  1  block can accept a word; registered.
- done  output  1  one-cycle pulse when a frame completes; registered.
- scl  output  1  serial clock; registered.
- sda  output  1  serial data; registered, push-pull.

One clock (`sclk`); reset `rst` is asynchronous and active-low.

## Operation
- Reset (asynchronous, immediate):
  - scl=1, sda=1, ready=1, done=0.
  - State IDLE; shift register and bit counter cleared.
- Accept: a word is accepted on a posedge where valid=1 and ready=1.
  - `data` is captured into the shift register.
  - When `PARITY_EN` is defined, the parity bit is also computed at that edge.
  - ready goes to 0 at the same edge.
- If valid=1 while ready=0, the word is ignored and nothing is captured.
- States and the outputs each one drives:
  - IDLE: scl=1, sda=1. On accept, go to START.
  - START, 1 cycle: scl=1, sda=0. This is SDA falling while SCL is high.
  - BIT_LO, 1 cycle: scl=0, sda=current bit. Next state is BIT_HI.
  - BIT_HI, 1 cycle: scl=1, sda held.
    - Shift to the next bit.
    - If bits remain, go to BIT_LO; otherwise go to STOP_LO.
  - STOP_LO: scl=0, sda=0.
  - STOP_HI: scl=1, sda=0.
  - STOP_REL: scl=1, sda=1. This is SDA rising while SCL is high.
    - ready returns to 1 and done pulses for 1 cycle.
    - State returns to IDLE.
- `sda` changes only while scl=0. The exceptions are the start and stop edges, which change while scl=1.
- Bit count per frame: NB = DATA_W, or DATA_W+1 when `PARITY_EN` is defined.
- The bit counter is $clog2(NB+1) wide and wraps to 0 at frame end.
- Reset asserted mid-frame:
  - The frame is abandoned and the line goes straight to idle (scl=1, sda=1).
  - No done pulse is produced.

## Timing
- Let E0 be the accept edge.
- After E1: first bit's BIT_LO.
- Bit k, for k = 0..NB-1:
  - BIT_LO after edge E(1+2k).
  - BIT_HI after edge E(2+2k).
- STOP_LO after E(1+2NB).
- STOP_HI after E(2+2NB).
- STOP_REL after E(3+2NB): ready=1 and done=1 here.
- ready is low for 2NB+3 cycles: 19 cycles for DATA_W=8 without parity, 21 with parity.
- Back-to-back frames (valid held high):
  - The next accept happens at the edge following ready=1.
  - That leaves exactly one cycle with scl=1, sda=1 between the stop and the next start.
- Latency from accept to the first data bit on `sda` is 1 cycle.

## Configuration
- `PARITY_EN` defined:
  - An even-parity bit, equal to the XOR of all DATA_W data bits, is sent as bit NB-1.
  - It uses the same BIT_LO/BIT_HI phases as the data bits and comes after the last data bit.
- `PARITY_EN` undefined:
  - No parity bit; NB = DATA_W.
  - No parity logic is synthesised.

## Test plan
- DATA_W=8, MSB_FIRST=1, data=0xA5, no parity:
  - sda sampled during each BIT_HI reads 1,0,1,0,0,1,0,1.
  - ready low for 19 cycles.
  - done pulses once, at the edge where ready rises.
- `PARITY_EN` defined:
  - data=0xA5 → parity bit 0.
  - data=0x07 → parity bit 1.
  - ready low for 21 cycles.
- MSB_FIRST=0, data=0x01 → BIT_HI samples read 1,0,0,0,0,0,0,0.
- valid held high with 0x3C then 0xC3:
  - Two complete frames are sent.
  - Exactly 1 idle cycle (scl=1, sda=1, ready=1) between them.
  - The second word is not corrupted by the first.
- Busy-period input: pulse valid with data=0xFF during bit 3 of a 0x00 frame.
  - All data BIT_HI samples stay 0.
  - No extra frame is sent.
- Reset mid-frame: assert rst during BIT_LO of bit 4.
  - scl=1, sda=1, ready=1, done=0 immediately.
  - After release, data=0x5A is sent correctly.
